grf_wport_arbiter: RTL
======================

// Module: grf_wport_arbiter
// PURPOSE
//  Shares the single GRF write port between the pipeline W stage and a long-latency unit (LL).
//  LL results (e.g. MDU-to-GPR ops) are buffered and committed in idle W-stage slots.
//  Keeps a per-register pending scoreboard and drives D-stage stall for RAW/WAW on pending regs.
//  Sits between W stage, LL unit and GRF; its grf_* outputs drive the GRF write port directly.
// PARAMETERS
//  LL_DEPTH     2   LL result buffer entries (power of 2, >=2)
//  MAX_OUT      4   max issued-but-uncommitted LL ops
//  STARVE_LIMIT 4   cycles a buffered head may wait before forcing pipeline bubbles
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  req        in   1   interrupt/exception request; suppresses the W-stage write this cycle
//  w_we       in   1   W-stage write enable
//  w_a3       in   5   W-stage destination register
//  w_wd       in   32  W-stage write data
//  w_pc       in   32  W-stage PC
//  iss_valid  in   1   LL op issued from D stage
//  iss_a3     in   5   LL op destination
//  iss_ready  out  1   issue accepted
//  ll_valid   in   1   LL result valid
//  ll_a3      in   5   LL result destination
//  ll_wd      in   32  LL result data
//  ll_pc      in   32  LL op PC
//  ll_ready   out  1   buffer can accept (= !full)
//  d_rs, d_rt in   5   D-stage source registers
//  d_wa       in   5   D-stage destination register
//  stall      out  1   freeze D stage
//  grf_we     out  1   GRF write enable
//  grf_a3     out  5   GRF write address
//  grf_wd     out  32  GRF write data
//  grf_pc     out  32  PC for the GRF write trace
// BEHAVIOUR
//  Reset: buffer empty, pending[31:0]=0, out_cnt=0, starve_cnt=0; iss_ready=1, ll_ready=1, stall=0.
//  pipe_w = w_we & !req & (w_a3!=0). If pipe_w: grf_* = W-stage fields (combinational, 0 latency).
//  Otherwise, if buffer nonempty: pop head; grf_we = (head.a3!=0), grf_a3/wd/pc = head fields.
//  Otherwise grf_we=0.
//  req never blocks the drain; an idle or suppressed W slot is usable.
//  LL push on ll_valid & ll_ready at the clock edge; earliest commit is the next cycle; FIFO order.
//  No push-when-full pass-through: ll_ready=0 when full, even if popping that cycle.
//  Push and pop in the same cycle are legal when not full.
//  iss_ready = (iss_a3==0 | !pending[iss_a3]) & (out_cnt < MAX_OUT).
//  Accepted issue: out_cnt+1; if iss_a3!=0, set pending[iss_a3] at the edge.
//  Every pop: out_cnt-1. If head.a3!=0, clear pending[head.a3].
//  Same-edge set and clear of the same register: set wins.
//  Simultaneous accepted issue and pop: out_cnt unchanged.
//  stall is computed from registered pending:
//   stall = (d_rs!=0 & pending[d_rs]) | (d_rt!=0 & pending[d_rt]) | (d_wa!=0 & pending[d_wa])
//           | (iss_valid & !iss_ready) | starve_hold.
//  Clearing pending takes effect the cycle after the commit edge, so the GRF already holds the value.
//  Starvation: starve_cnt increments each cycle the buffer is nonempty and pipe_w blocks the pop.
//   It resets to 0 on any pop or when the buffer is empty.
//   starve_hold = (starve_cnt >= STARVE_LIMIT); stall holds until bubbles reach W and a pop occurs.
//  Reset mid-operation drops buffered results and clears the scoreboard. The LL unit is reset too.
// STRUCTURE
//  Shared package cpu_defs: REG_W=5, DATA_W=32, and the typedef/struct wb_entry {a3, wd, pc}.
//  Sub-module wb_fifo: synchronous FIFO of wb_entry, LL_DEPTH deep, with full/empty and push/pop.
//  Scoreboard, counters and mux stay in the top module.
// TESTING
//  1) After reset: w_we=1, w_a3=5, w_wd=0x1234, w_pc=0x3000 -> same cycle grf_we=1, grf_a3=5, grf_wd=0x1234.
//  2) iss a3=8 -> next cycle d_rs=8 gives stall=1.
//     Then ll a3=8, wd=0xdead with w_we=0 -> next cycle grf_we=1 a3=8; stall=0 the cycle after.
//  3) Buffer holds a3=9 while w_we=1, a3=3 -> GRF writes $3, entry kept.
//     Next cycle w_we=0 -> GRF writes $9.
//  4) Buffer nonempty, w_we=1 for 6 cycles, STARVE_LIMIT=4 -> stall=1 from the 5th blocked cycle.
//     stall drops after the pop.
//  5) req=1 with w_we=1 a3=4 and buffer empty -> grf_we=0.
//     LL result a3=0 -> popped with grf_we=0; out_cnt decrements; pending unchanged.
//  6) Two results pushed with no W idle slot -> ll_ready=0; a third ll_valid is not accepted.
//     4 issues outstanding -> iss_ready=0 and stall=1.

Source files
------------

// File: rtl/grf_wport_arbiter_pkg.sv
// Shared CPU datapath definitions: register/data widths and the write-back entry
// carried from the long-latency unit to the GRF write port.
package cpu_defs;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_entry;

endpackage

// File: rtl/grf_wport_arbiter_wb_fifo.sv
// Synchronous FIFO of write-back entries for buffered long-latency results.
// First-word fall-through: head is valid whenever empty is low.
module wb_fifo
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_entry din,
  input  logic    pop,
  output wb_entry head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry        mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter: W stage has priority, buffered long-latency results drain
// into idle W slots, and a pending scoreboard stalls D on hazards against them.
module grf_wport_arbiter
  import cpu_defs::*;
#(
  parameter int LL_DEPTH     = 2,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              w_we,
  input  logic [REG_W-1:0]  w_a3,
  input  logic [DATA_W-1:0] w_wd,
  input  logic [DATA_W-1:0] w_pc,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_a3,
  output logic              iss_ready,
  input  logic              ll_valid,
  input  logic [REG_W-1:0]  ll_a3,
  input  logic [DATA_W-1:0] ll_wd,
  input  logic [DATA_W-1:0] ll_pc,
  output logic              ll_ready,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  input  logic [REG_W-1:0]  d_wa,
  output logic              stall,
  output logic              grf_we,
  output logic [REG_W-1:0]  grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_pc
);

  localparam int NREG  = 1 << REG_W;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wb_entry          head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pipe_w;
  logic             pop;
  logic             push;
  logic             iss_acc;
  logic             starve_hold;
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic [CNT_W-1:0] out_cnt;
  logic [STV_W-1:0] starve_cnt;

  wb_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ('{a3: ll_a3, wd: ll_wd, pc: ll_pc}),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A suppressed or $0 W-stage write leaves the port free for the buffer.
  assign pipe_w    = w_we && !req && (w_a3 != '0);
  assign pop       = !fifo_empty && !pipe_w;
  assign ll_ready  = !fifo_full;
  assign push      = ll_valid && ll_ready;
  assign iss_ready = ((iss_a3 == '0) || !pending[iss_a3]) && (out_cnt < CNT_W'(MAX_OUT));
  assign iss_acc   = iss_valid && iss_ready;

  assign starve_hold = (starve_cnt >= STV_W'(STARVE_LIMIT));
  assign stall = ((d_rs != '0) && pending[d_rs])
               | ((d_rt != '0) && pending[d_rt])
               | ((d_wa != '0) && pending[d_wa])
               | (iss_valid && !iss_ready)
               | starve_hold;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    grf_pc = '0;
    if (pipe_w) begin
      grf_we = 1'b1;
      grf_a3 = w_a3;
      grf_wd = w_wd;
      grf_pc = w_pc;
    end else if (!fifo_empty) begin
      grf_we = (head.a3 != '0);
      grf_a3 = head.a3;
      grf_wd = head.wd;
      grf_pc = head.pc;
    end
  end

  // Clear before set so a same-edge issue to a just-committed register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (pop && (head.a3 != '0)) pending_nxt[head.a3] = 1'b0;
    if (iss_acc && (iss_a3 != '0)) pending_nxt[iss_a3] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      out_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      case ({iss_acc, pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      // Saturates at the limit; only the threshold crossing matters.
      if (fifo_empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != STV_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
